// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the elastic pipeline stage.
//
// Contents:
//   PIPE_PC_W / PIPE_DATA_W / PIPE_CTRL_W : default payload widths
//   occ_t                                 : 2-bit held-beat count (0..2)
//   occ_count()                           : sums two slot-valid bits into occ_t
package pipe_pkg;

    localparam int PIPE_PC_W   = 12;
    localparam int PIPE_DATA_W = 96;
    localparam int PIPE_CTRL_W = 13;

    typedef logic [1:0] occ_t;

    function automatic occ_t occ_count(input logic a, input logic b);
        return occ_t'({1'b0, a}) + occ_t'({1'b0, b});
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// pipe_entry -- one storage slot of the elastic stage (valid + pc + data + ctrl).
//
// Ports:
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset, clears every field
//   i_en     : load the slot from i_vld/i_pc/i_data/i_ctrl at the edge
//   i_clr    : invalidate the slot and clear its ctrl bits (wins over i_en)
//   i_vld    : valid bit to load; loading a bubble also clears ctrl
//   i_pc     : program counter to load
//   i_data   : data payload to load
//   i_ctrl   : control payload to load
//   o_valid  : slot holds a beat
//   o_pc     : stored program counter
//   o_data   : stored data payload
//   o_ctrl   : stored control payload (zero whenever the slot is empty)
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int PC_W   = PIPE_PC_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_vld,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [PC_W-1:0]   o_pc,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_en) begin
            r_valid <= i_vld;
            r_pc    <= i_pc;
            r_data  <= i_data;
            // A bubble never carries control bits.
            r_ctrl  <= i_vld ? i_ctrl : '0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic -- elastic pipeline register with flush and stall.
//
// Build option: define PIPE_STAGE_SKID_EN for skid mode (main + skid slot,
// occupancy 0..2, in_ready driven from the skid-valid flop). Without it the
// stage is a single slot (occupancy 0..1) with a combinational in_ready.
//
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset, drops all held beats
//   in_valid   : upstream beat offered
//   in_ready   : stage can accept the offered beat
//   in_pc      : upstream program counter
//   in_data    : upstream data payload
//   in_ctrl    : upstream control payload
//   out_valid  : downstream beat presented
//   out_ready  : downstream takes the beat
//   out_pc     : downstream program counter
//   out_data   : downstream data payload
//   out_ctrl   : downstream control payload, zero whenever out_valid=0
//   flush      : discard all held beats (beats priority over stall/accept/emit)
//   stall      : freeze both handshakes
//   occupancy  : number of held beats
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int PC_W   = PIPE_PC_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              stall,
    output occ_t              occupancy
);

    logic              w_main_valid;
    logic [PC_W-1:0]   w_main_pc;
    logic [DATA_W-1:0] w_main_data;
    logic [CTRL_W-1:0] w_main_ctrl;

    logic              w_main_en;
    logic              w_main_vld_d;
    logic [PC_W-1:0]   w_main_pc_d;
    logic [DATA_W-1:0] w_main_data_d;
    logic [CTRL_W-1:0] w_main_ctrl_d;

    logic              w_accept;

    // Output side: stall hides the held beat, and the ctrl mask keeps
    // bubbles (including stalled beats) free of control bits.
    assign out_valid = w_main_valid & ~stall;
    assign out_pc    = w_main_pc;
    assign out_data  = w_main_data;
    assign out_ctrl  = out_valid ? w_main_ctrl : '0;

    assign w_accept  = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN

    logic              w_skid_valid;
    logic [PC_W-1:0]   w_skid_pc;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic              w_skid_en;
    logic              w_skid_vld_d;
    logic              w_emit;
    logic              w_skid_to_main;

    assign w_emit         = out_valid & out_ready;
    assign w_skid_to_main = w_emit & w_skid_valid;

    // in_ready comes straight from the skid-valid flop (gated only by
    // stall), so there is no combinational path from out_ready.
    assign in_ready = ~w_skid_valid & ~stall;

    // Main refills whenever it empties or emits: from skid if skid holds
    // the older beat, otherwise from the input (a bubble if no accept).
    assign w_main_en     = w_emit | ~w_main_valid;
    assign w_main_vld_d  = w_skid_to_main | w_accept;
    assign w_main_pc_d   = w_skid_to_main ? w_skid_pc   : in_pc;
    assign w_main_data_d = w_skid_to_main ? w_skid_data : in_data;
    assign w_main_ctrl_d = w_skid_to_main ? w_skid_ctrl : in_ctrl;

    // Skid captures a beat only when main is full and not draining; it
    // empties when its beat moves into main.
    assign w_skid_vld_d = w_accept & w_main_valid & ~w_emit;
    assign w_skid_en    = w_skid_vld_d | w_skid_to_main;

    pipe_entry #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_en    (w_skid_en),
        .i_clr   (flush),
        .i_vld   (w_skid_vld_d),
        .i_pc    (in_pc),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_valid (w_skid_valid),
        .o_pc    (w_skid_pc),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
    );

    assign occupancy = occ_count(w_main_valid, w_skid_valid);

`else

    // Single slot: load whenever the slot is empty or being drained.
    assign in_ready      = ~stall & (~w_main_valid | out_ready);
    assign w_main_en     = in_ready;
    assign w_main_vld_d  = w_accept;
    assign w_main_pc_d   = in_pc;
    assign w_main_data_d = in_data;
    assign w_main_ctrl_d = in_ctrl;

    assign occupancy = occ_count(w_main_valid, 1'b0);

`endif

    // Main slot: the beat presented downstream.
    pipe_entry #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clock   (clock),
        .reset   (reset),
        .i_en    (w_main_en),
        .i_clr   (flush),
        .i_vld   (w_main_vld_d),
        .i_pc    (w_main_pc_d),
        .i_data  (w_main_data_d),
        .i_ctrl  (w_main_ctrl_d),
        .o_valid (w_main_valid),
        .o_pc    (w_main_pc),
        .o_data  (w_main_data),
        .o_ctrl  (w_main_ctrl)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic -- self-checking bench for pipe_stage_elastic.
// Works in both builds (PIPE_STAGE_SKID_EN defined or not).
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    localparam int PC_W   = 12;
    localparam int DATA_W = 96;
    localparam int CTRL_W = 13;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              flush;
    logic              stall;
    occ_t              occupancy;

    pipe_stage_elastic #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .flush     (flush),
        .stall     (stall),
        .occupancy (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a FIFO of held beats ----------------
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } beat_t;

    beat_t q[$];

    function automatic logic model_ready();
`ifdef PIPE_STAGE_SKID_EN
        return !stall && (q.size() < CAP);
`else
        return !stall && (q.size() == 0 || out_ready);
`endif
    endfunction

    always @(negedge reset) q.delete();

    always @(posedge clock) begin
        if (reset) begin
            logic acc, emit;
            acc  = in_valid && model_ready() && !flush;
            emit = (q.size() > 0) && !stall && out_ready && !flush;
            if (flush) q.delete();
            else begin
                if (emit) void'(q.pop_front());
                if (acc)  q.push_back('{pc: in_pc, data: in_data, ctrl: in_ctrl});
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clock) begin
        logic exp_vld;
        exp_vld = (q.size() > 0) && !stall;
        chk("in_ready", in_ready, model_ready());
        chk("out_valid", out_valid, exp_vld);
        chk("occupancy", occupancy, q.size());
        if (exp_vld) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_data", out_data, q[0].data);
            chk("out_ctrl", out_ctrl, q[0].ctrl);
        end else begin
            chk("bubble_ctrl", out_ctrl, 0);
        end
    end

    // ---------------- streaming monitor ----------------
    int   cyc = 0;
    logic stream_mon = 1'b0;
    int   emit_n, first_cyc, last_cyc;
    logic [PC_W-1:0] first_pc, last_pc;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (stream_mon && out_valid && out_ready) begin
            if (emit_n == 0) begin
                first_cyc = cyc;
                first_pc  = out_pc;
            end
            last_cyc = cyc;
            last_pc  = out_pc;
            emit_n++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0; flush = 1'b0; stall = 1'b0;
        emit_n = 0; first_cyc = 0; last_cyc = 0; first_pc = '0; last_pc = '0;

        // Reset state
        repeat (2) step();
        @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        step();
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", in_ready, 1);

        // Single beat
        step();
        in_valid = 1'b1; in_pc = 12'h01A; in_ctrl = 13'h1F3; in_data = rnd_data(); out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clock);
        chk("single_valid", out_valid, 1);
        chk("single_pc", out_pc, 12'h01A);
        chk("single_ctrl", out_ctrl, 13'h1F3);
        step();
        @(negedge clock);
        chk("single_occ_after", occupancy, 0);

        // Fill with out_ready low
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 12'h010; in_ctrl = 13'h011; in_data = rnd_data();
        step();
        in_pc = 12'h011; in_ctrl = 13'h022; in_data = rnd_data();
        step();
        @(negedge clock);
        chk("fill_occ", occupancy, CAP);
        chk("fill_ready", in_ready, 0);
        step();
        out_ready = 1'b1;
        @(negedge clock);
        chk("fill_first_valid", out_valid, 1);
        chk("fill_first_pc", out_pc, 12'h010);
        step();
        in_valid = 1'b0;
        @(negedge clock);
        chk("fill_second_valid", out_valid, 1);
        chk("fill_second_pc", out_pc, 12'h011);
        step();
        @(negedge clock);
        chk("fill_drained", occupancy, 0);

        // Stall for 3 cycles with one held beat
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 12'h0A5; in_ctrl = 13'h0C3; in_data = rnd_data();
        step();
        in_valid = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_valid", out_valid, 0);
            chk("stall_ctrl", out_ctrl, 0);
            chk("stall_ready", in_ready, 0);
            chk("stall_occ", occupancy, 1);
            step();
        end
        stall = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        chk("stall_release_valid", out_valid, 1);
        chk("stall_release_pc", out_pc, 12'h0A5);
        step();
        @(negedge clock);
        chk("stall_drained", occupancy, 0);

        // Flush a full stage with a beat offered
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 12'h020; in_ctrl = 13'h1AA; in_data = rnd_data();
        step();
        in_pc = 12'h021;
        step();
        in_pc = 12'h0FF; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("flush_occ", occupancy, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_ctrl", out_ctrl, 0);
        step();
        out_ready = 1'b1;
        // Flush an empty stage while a beat is accepted-eligible
        in_valid = 1'b1; in_pc = 12'h0FE; in_ctrl = 13'h1FF; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("flush_offer_occ", occupancy, 0);
        chk("flush_offer_valid", out_valid, 0);
        step();

        // Streaming 100 beats
        out_ready = 1'b1; stream_mon = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_pc = PC_W'(i); in_ctrl = CTRL_W'($urandom); in_data = rnd_data();
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        stream_mon = 1'b0;
        chk("stream_count", emit_n, 100);
        chk("stream_no_gaps", last_cyc - first_cyc, 99);
        chk("stream_first_pc", first_pc, 0);
        chk("stream_last_pc", last_pc, 99);

        // Asynchronous reset between edges
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 12'h033; in_ctrl = 13'h0F0; in_data = rnd_data();
        step();
        in_valid = 1'b0;
        #1;
        chk("pre_async_occ", occupancy, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_occ", occupancy, 0);
        step();
        reset = 1'b1;
        step();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            stall     = ($urandom_range(0, 15) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_pc     = PC_W'($urandom);
            in_ctrl   = CTRL_W'($urandom);
            in_data   = rnd_data();
            step();
        end
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
